load_store_unit: RTL and testbench

Memory-side responder for the load/store control signals (MemWrite, SizeSrc, LoadSign) the decoder issues for RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW. Sits between the execute/memory stage and a word-wide synchronous-read data RAM. Handles byte lanes, sign/zero extension and misaligned accesses that span two words, using a small FSM with a stall handshake back to the pipeline.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/load_store_unit_if.sv | 22 ++
 rtl/load_store_unit_load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store encodings: SizeSrc sizes, LSU FSM states and lane-mask helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LD_DATA = 2'b01,
        LD_HI   = 2'b10,
        ST_HI   = 2'b11
    } state_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // The reserved SizeSrc code 2'b11 behaves as a word access.
    function automatic size_e norm_size(input logic [1:0] s);
        case (s)
            2'b01:   return SIZE_HALF;
            2'b10:   return SIZE_BYTE;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic [3:0] base_mask(input size_e s);
        case (s)
            SIZE_HALF: return MASK_HALF;
            SIZE_BYTE: return MASK_BYTE;
            default:   return MASK_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e s, input logic [1:0] o);
        case (s)
            SIZE_HALF: return (o == 2'd3);
            SIZE_BYTE: return 1'b0;
            default:   return (o != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bundle of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        mem_write;
    logic [1:0]  size_src;
    logic        load_sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        rdata_valid;
    logic [31:0] rdata;

    modport master (
        output req_valid, mem_write, size_src, load_sign, addr, wdata,
        input  stall, rdata_valid, rdata
    );

    modport slave (
        input  req_valid, mem_write, size_src, load_sign, addr, wdata,
        output stall, rdata_valid, rdata
    );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Lane select from a two-word read window plus byte/half sign or zero extension.
module load_extend
    import lsu_pkg::*;
(
    input  logic [63:0] i_window,
    input  logic [1:0]  i_offset,
    input  size_e       i_size,
    input  logic        i_sign,
    output logic [31:0] o_data
);
    logic [31:0] w_shift;

    assign w_shift = 32'(i_window >> {i_offset, 3'b000});

    always_comb begin
        case (i_size)
            SIZE_BYTE: o_data = {{24{i_sign & w_shift[7]}}, w_shift[7:0]};
            SIZE_HALF: o_data = {{16{i_sign & w_shift[15]}}, w_shift[15:0]};
            default:   o_data = w_shift;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store responder: byte lanes, extension and two-beat misaligned accesses
// against a word-wide synchronous-read RAM, stalling the pipeline as needed.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      bus,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic                  ram_we,
    output logic [3:0]            ram_be,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);
    localparam int WORD_ADDR_W = ADDR_WIDTH - 2;

    state_e                 r_state, w_next;
    logic [1:0]             r_off;
    size_e                  r_size;
    logic                   r_sign;
    logic                   r_mis;
    logic [WORD_ADDR_W-1:0] r_addr_hi;
    logic [3:0]             r_be_hi;
    logic [31:0]            r_wd_hi;
    logic [31:0]            r_lo;
    logic [31:0]            r_rdata;

    size_e                  w_size;
    logic [1:0]             w_off;
    logic [WORD_ADDR_W-1:0] w_word, w_word_nxt;
    logic                   w_mis;
    logic [3:0]             w_mask, w_be0, w_be1;
    logic [31:0]            w_wd0, w_wd1;
    logic [63:0]            w_window;
    logic [31:0]            w_ext;
    logic                   w_rvalid;
    logic                   w_unused_addr;

    assign w_size        = norm_size(bus.size_src);
    assign w_off         = bus.addr[1:0];
    assign w_word        = bus.addr[ADDR_WIDTH-1:2];
    assign w_word_nxt    = w_word + WORD_ADDR_W'(1);
    assign w_mis         = is_misaligned(w_size, w_off);
    assign w_mask        = base_mask(w_size);
    assign w_be0         = w_mask << w_off;
    assign w_be1         = w_mask >> (3'd4 - {1'b0, w_off});
    assign w_wd0         = bus.wdata << {w_off, 3'b000};
    assign w_wd1         = bus.wdata >> (6'd32 - {1'b0, w_off, 3'b000});
    assign w_unused_addr = ^bus.addr[31:ADDR_WIDTH];

    load_extend u_ext (
        .i_window (w_window),
        .i_offset (r_off),
        .i_size   (r_size),
        .i_sign   (r_sign),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_off     <= '0;
            r_size    <= SIZE_WORD;
            r_sign    <= 1'b0;
            r_mis     <= 1'b0;
            r_addr_hi <= '0;
            r_be_hi   <= '0;
            r_wd_hi   <= '0;
            r_lo      <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.req_valid) begin
                r_off     <= w_off;
                r_size    <= w_size;
                r_sign    <= bus.load_sign;
                r_mis     <= w_mis;
                r_addr_hi <= w_word_nxt;
                r_be_hi   <= w_be1;
                r_wd_hi   <= w_wd1;
            end
            if (r_state == LD_DATA) r_lo <= ram_rdata;
            if (w_rvalid) r_rdata <= w_ext;
        end
    end

    always_comb begin
        w_next          = r_state;
        ram_addr        = '0;
        ram_we          = 1'b0;
        ram_be          = '0;
        ram_wdata       = '0;
        bus.stall       = 1'b0;
        w_rvalid        = 1'b0;
        w_window        = {32'h0, ram_rdata};
        case (r_state)
            IDLE: if (bus.req_valid) begin
                ram_addr = w_word;
                if (bus.mem_write) begin
                    ram_we    = 1'b1;
                    ram_be    = w_be0;
                    ram_wdata = w_wd0;
                    if (w_mis) begin
                        bus.stall = 1'b1;
                        w_next    = ST_HI;
                    end
                end else begin
                    bus.stall = 1'b1;
                    w_next    = LD_DATA;
                end
            end
            LD_DATA: if (r_mis) begin
                ram_addr  = r_addr_hi;
                bus.stall = 1'b1;
                w_next    = LD_HI;
            end else begin
                w_rvalid = 1'b1;
                w_next   = IDLE;
            end
            LD_HI: begin
                w_window = {ram_rdata, r_lo};
                w_rvalid = 1'b1;
                w_next   = IDLE;
            end
            ST_HI: begin
                ram_addr  = r_addr_hi;
                ram_we    = 1'b1;
                ram_be    = r_be_hi;
                ram_wdata = r_wd_hi;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Reset abandons any in-flight access: nothing reaches the RAM or pipeline.
        if (rst) begin
            ram_addr  = '0;
            ram_we    = 1'b0;
            ram_be    = '0;
            ram_wdata = '0;
            bus.stall = 1'b0;
            w_rvalid  = 1'b0;
        end
    end

    assign bus.rdata_valid = w_rvalid;
    assign bus.rdata       = w_rvalid ? w_ext : r_rdata;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous-read word RAM.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem [0:32767];
    int          n_tests = 0;
    int          n_fail  = 0;

    load_store_unit_if bus();

    load_store_unit #(.ADDR_WIDTH(17)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        ram_rdata <= mem[ram_addr];
    end

    task automatic issue(input logic mw, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.mem_write = mw;
        bus.size_src  = sz;
        bus.load_sign = sg;
        bus.addr      = a;
        bus.wdata     = d;
    endtask

    task automatic release_req();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.mem_write = 1'b0; bus.size_src = 2'b00;
        bus.load_sign = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", bus.stall); end
        n_tests++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b exp 0", bus.rdata_valid); end
        n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
        n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", ram_we); end
        n_tests++; if (ram_be !== 4'h0) begin n_fail++; $display("FAIL rst_be got %b exp 0", ram_be); end
        n_tests++; if (ram_addr !== 15'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", ram_addr); end
        n_tests++; if (ram_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0", ram_wdata); end
    endtask

    task automatic test_store_word();
        issue(1'b1, 2'b00, 1'b0, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        n_tests++; if (ram_addr !== 15'h40) begin n_fail++; $display("FAIL sw_addr got %h exp 40", ram_addr); end
        n_tests++; if (ram_be !== 4'b1111) begin n_fail++; $display("FAIL sw_be got %b exp 1111", ram_be); end
        n_tests++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL sw_we got %b exp 1", ram_we); end
        n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL sw_stall got %b exp 0", bus.stall); end
        n_tests++; if (ram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got %h exp DEADBEEF", ram_wdata); end
        release_req();
        @(negedge clk);
        n_tests++; if (ram_we !== 1'b0 || ram_be !== 4'h0) begin n_fail++; $display("FAIL idle_we_be got %b/%b exp 0/0", ram_we, ram_be); end
        n_tests++; if (mem[15'h40] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem got %h exp DEADBEEF", mem[15'h40]); end
    endtask

    task automatic test_byte();
        logic        sg;
        logic [31:0] exp;
        issue(1'b1, 2'b10, 1'b0, 32'h103, 32'h000000A5);
        @(negedge clk);
        n_tests++; if (ram_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be got %b exp 1000", ram_be); end
        n_tests++; if (ram_wdata !== 32'hA5000000) begin n_fail++; $display("FAIL sb_wdata got %h exp A5000000", ram_wdata); end
        release_req();
        for (int k = 0; k < 2; k++) begin
            sg  = (k == 0);
            exp = sg ? 32'hFFFFFFA5 : 32'h000000A5;
            issue(1'b0, 2'b10, sg, 32'h103, 32'h0);
            @(negedge clk);
            n_tests++; if (bus.stall !== 1'b1 || ram_addr !== 15'h40 || ram_we !== 1'b0) begin
                n_fail++; $display("FAIL lb_req sg=%0b got stall=%b addr=%h we=%b exp 1/40/0", sg, bus.stall, ram_addr, ram_we); end
            @(negedge clk);
            n_tests++; if (bus.stall !== 1'b0 || bus.rdata_valid !== 1'b1) begin
                n_fail++; $display("FAIL lb_done sg=%0b got stall=%b rvalid=%b exp 0/1", sg, bus.stall, bus.rdata_valid); end
            n_tests++; if (bus.rdata !== exp) begin n_fail++; $display("FAIL lb_rdata sg=%0b got %h exp %h", sg, bus.rdata, exp); end
            release_req();
            @(negedge clk);
            n_tests++; if (bus.rdata_valid !== 1'b0 || bus.rdata !== exp) begin
                n_fail++; $display("FAIL lb_hold sg=%0b got rvalid=%b rdata=%h exp 0/%h", sg, bus.rdata_valid, bus.rdata, exp); end
        end
    endtask

    task automatic test_misaligned_load();
        issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h44332211); release_req();
        issue(1'b1, 2'b00, 1'b0, 32'h104, 32'h88776655); release_req();
        issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        @(negedge clk); @(negedge clk);
        n_tests++; if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'h00004433) begin
            n_fail++; $display("FAIL lhu_aligned got rvalid=%b rdata=%h exp 1/00004433", bus.rdata_valid, bus.rdata); end
        release_req();
        issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0);
        @(negedge clk);
        n_tests++; if (ram_addr !== 15'h40 || bus.stall !== 1'b1) begin
            n_fail++; $display("FAIL lw_mis_b0 got addr=%h stall=%b exp 40/1", ram_addr, bus.stall); end
        @(negedge clk);
        n_tests++; if (ram_addr !== 15'h41 || bus.stall !== 1'b1 || bus.rdata_valid !== 1'b0) begin
            n_fail++; $display("FAIL lw_mis_b1 got addr=%h stall=%b rvalid=%b exp 41/1/0", ram_addr, bus.stall, bus.rdata_valid); end
        @(negedge clk);
        n_tests++; if (bus.stall !== 1'b0 || bus.rdata_valid !== 1'b1 || bus.rdata !== 32'h66554433) begin
            n_fail++; $display("FAIL lw_mis_done got stall=%b rvalid=%b rdata=%h exp 0/1/66554433", bus.stall, bus.rdata_valid, bus.rdata); end
        release_req();
    endtask

    task automatic test_misaligned_half();
        issue(1'b1, 2'b00, 1'b0, 32'h108, 32'h0); release_req();
        issue(1'b1, 2'b01, 1'b0, 32'h107, 32'h0000BEEF);
        @(negedge clk);
        n_tests++; if (ram_addr !== 15'h41 || ram_be !== 4'b1000 || ram_wdata !== 32'hEF000000 || ram_we !== 1'b1 || bus.stall !== 1'b1) begin
            n_fail++; $display("FAIL sh_b0 got addr=%h be=%b data=%h we=%b stall=%b exp 41/1000/EF000000/1/1", ram_addr, ram_be, ram_wdata, ram_we, bus.stall); end
        @(negedge clk);
        n_tests++; if (ram_addr !== 15'h42 || ram_be !== 4'b0001 || ram_wdata !== 32'h000000BE || ram_we !== 1'b1 || bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL sh_b1 got addr=%h be=%b data=%h we=%b stall=%b exp 42/0001/000000BE/1/0", ram_addr, ram_be, ram_wdata, ram_we, bus.stall); end
        release_req();
        @(negedge clk);
        n_tests++; if (mem[15'h41] !== 32'hEF776655 || mem[15'h42] !== 32'h000000BE) begin
            n_fail++; $display("FAIL sh_mem got %h/%h exp EF776655/000000BE", mem[15'h41], mem[15'h42]); end
        issue(1'b0, 2'b01, 1'b1, 32'h107, 32'h0);
        @(negedge clk); @(negedge clk);
        n_tests++; if (bus.stall !== 1'b1 || ram_addr !== 15'h42) begin
            n_fail++; $display("FAIL lh_mis_b1 got stall=%b addr=%h exp 1/42", bus.stall, ram_addr); end
        @(negedge clk);
        n_tests++; if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'hFFFFBEEF) begin
            n_fail++; $display("FAIL lh_mis got rvalid=%b rdata=%h exp 1/FFFFBEEF", bus.rdata_valid, bus.rdata); end
        release_req();
    endtask

    task automatic test_wrap();
        issue(1'b1, 2'b00, 1'b0, 32'h1FFFC, 32'hAABBCCDD); release_req();
        issue(1'b1, 2'b00, 1'b0, 32'h0, 32'h11223344); release_req();
        issue(1'b0, 2'b00, 1'b0, 32'h1FFFD, 32'h0);
        @(negedge clk);
        n_tests++; if (ram_addr !== 15'h7FFF) begin n_fail++; $display("FAIL wrap_b0 got addr=%h exp 7FFF", ram_addr); end
        @(negedge clk);
        n_tests++; if (ram_addr !== 15'h0000 || bus.stall !== 1'b1) begin
            n_fail++; $display("FAIL wrap_b1 got addr=%h stall=%b exp 0000/1", ram_addr, bus.stall); end
        @(negedge clk);
        n_tests++; if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'h44AABBCC) begin
            n_fail++; $display("FAIL wrap_rdata got rvalid=%b rdata=%h exp 1/44AABBCC", bus.rdata_valid, bus.rdata); end
        release_req();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0);
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; bus.req_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (ram_we !== 1'b0 || bus.rdata_valid !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_ldhi got we=%b rvalid=%b stall=%b exp 0/0/0", ram_we, bus.rdata_valid, bus.stall); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.stall !== 1'b0 || bus.rdata_valid !== 1'b0 || bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL rst_ldhi_after got stall=%b rvalid=%b rdata=%h exp 0/0/0", bus.stall, bus.rdata_valid, bus.rdata); end
        issue(1'b1, 2'b00, 1'b0, 32'h204, 32'h0); release_req();
        issue(1'b1, 2'b00, 1'b0, 32'h208, 32'hCAFEF00D); release_req();
        issue(1'b1, 2'b00, 1'b0, 32'h205, 32'h12345678);
        @(negedge clk);
        n_tests++; if (bus.stall !== 1'b1 || ram_be !== 4'b1110) begin
            n_fail++; $display("FAIL st_mis_b0 got stall=%b be=%b exp 1/1110", bus.stall, ram_be); end
        @(posedge clk); #1;
        rst = 1'b1; bus.req_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (ram_we !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL rst_sthi got we=%b stall=%b exp 0/0", ram_we, bus.stall); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_tests++; if (mem[15'h82] !== 32'hCAFEF00D || mem[15'h81] !== 32'h34567800) begin
            n_fail++; $display("FAIL rst_sthi_mem got %h/%h exp 34567800/CAFEF00D", mem[15'h81], mem[15'h82]); end
        issue(1'b1, 2'b00, 1'b0, 32'h300, 32'h0BADCAFE);
        @(negedge clk);
        n_tests++; if (ram_we !== 1'b1 || ram_addr !== 15'hC0 || bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_sw got we=%b addr=%h stall=%b exp 1/C0/0", ram_we, ram_addr, bus.stall); end
        release_req();
        @(negedge clk);
        n_tests++; if (mem[15'hC0] !== 32'h0BADCAFE) begin n_fail++; $display("FAIL post_rst_mem got %h exp 0BADCAFE", mem[15'hC0]); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_byte();
        test_misaligned_load();
        test_misaligned_half();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
